frame_buffer_writer: RTL and testbench

- Writer side of the 320x240 12-bit frame buffer BRAM that the VGA display path reads.
- Accepts a raster-ordered pixel stream over a valid/ready handshake with start-of-frame and end-of-line markers.
- Generates BRAM port writes (wea/addra/dina) using an incremental row-base address, with no multiplier.
- Sits between a pixel source (camera capture, pattern or sprite generator) and the BRAM write port.

---
 rtl/frame_buffer_writer_if.sv | 14 +
 rtl/frame_buffer_writer.sv | 154 +++++++++++++++
 tb/tb_frame_buffer_writer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_writer_if.sv
// Raster pixel stream from a source into the frame buffer writer: valid/ready with sof/eol markers.
// The source drives the beat (master); the writer returns ready (slave).
interface frame_buffer_writer_if #(
  parameter int DW = 12
) ();
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_sof;
  logic          s_eol;

  modport master (output s_valid, s_data, s_sof, s_eol, input s_ready);
  modport slave  (input s_valid, s_data, s_sof, s_eol, output s_ready);
endinterface

// File: rtl/frame_buffer_writer.sv
// Writes a raster pixel stream into the frame buffer BRAM; 1-cycle registered write, ready only depends on state.
// `define FRAME_WR_HMIRROR_EN to store each line horizontally mirrored.
module frame_buffer_writer #(
  parameter int H_PIX      = 320,
  parameter int V_PIX      = 240,
  parameter int DW         = 12,
  parameter int AW         = 17,
  parameter int CONTINUOUS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  frame_buffer_writer_if.slave  pix,
  output logic                  wea,
  output logic [AW-1:0]         addra,
  output logic [DW-1:0]         dina,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YW = (V_PIX > 1) ? $clog2(V_PIX + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, WRITE, DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   row_base_q, row_base_d;
  logic            err_q, err_d;
  logic            wea_q;
  logic [AW-1:0]   addra_q;
  logic [DW-1:0]   dina_q;

  logic            accept;
  logic            wr_en;
  logic [AW-1:0]   wr_base;
  logic [XW-1:0]   wr_col;
  logic [AW-1:0]   wr_addr;
  logic            last_col;
  logic            last_row;

  assign accept   = pix.s_valid && pix.s_ready;
  assign last_col = (x_q == XW'(H_PIX - 1));
  assign last_row = (y_q == YW'(V_PIX - 1));

`ifdef FRAME_WR_HMIRROR_EN
  assign wr_addr = wr_base + AW'(H_PIX - 1) - AW'(wr_col);
`else
  assign wr_addr = wr_base + AW'(wr_col);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      err_q      <= 1'b0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      err_q      <= err_d;
      wea_q      <= wr_en;
      if (wr_en) begin
        addra_q <= wr_addr;
        dina_q  <= pix.s_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    wr_base    = '0;
    wr_col     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WAIT_SOF;
          err_d      = 1'b0;
          x_d        = '0;
          y_d        = '0;
          row_base_d = '0;
        end
      end
      WAIT_SOF: begin
        if (accept && pix.s_sof) begin
          wr_en      = 1'b1;
          x_d        = XW'(1);
          y_d        = '0;
          row_base_d = '0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (pix.s_sof) begin
            // A new frame restarts mid-frame: resync to its first pixel.
            err_d      = 1'b1;
            x_d        = XW'(1);
            y_d        = '0;
            row_base_d = '0;
          end else begin
            wr_base = row_base_q;
            wr_col  = x_q;
            if (pix.s_eol != last_col) begin
              err_d = 1'b1;
            end
            if (last_col && last_row) begin
              state_d    = DONE;
              x_d        = '0;
              y_d        = '0;
              row_base_d = '0;
            end else if (pix.s_eol || last_col) begin
              x_d        = '0;
              y_d        = y_q + YW'(1);
              row_base_d = row_base_q + AW'(H_PIX);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = (CONTINUOUS != 0) ? WAIT_SOF : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix.s_ready = (state_q == WAIT_SOF) || (state_q == WRITE);
    busy        = (state_q == WAIT_SOF) || (state_q == WRITE);
    done        = (state_q == DONE);
  end

  assign wea   = wea_q;
  assign addra = addra_q;
  assign dina  = dina_q;
  assign err   = err_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Randomized stimulus against a pixel-coordinate model of the frame buffer writer, on a reduced 20x6 frame.
module tb_frame_buffer_writer;
  localparam int H  = 20;
  localparam int V  = 6;
  localparam int DW = 12;
  localparam int AW = 17;
`ifdef FRAME_WR_HMIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          busy;
  logic          done;
  logic          err;

  frame_buffer_writer_if #(.DW(DW)) pix ();

  frame_buffer_writer #(
    .H_PIX(H), .V_PIX(V), .DW(DW), .AW(AW), .CONTINUOUS(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pix(pix.slave),
    .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int wr_log[$];

  // Model: mode 0 idle, 1 waiting for sof, 2 in frame, 3 frame-complete cycle
  int m_mode = 0, m_x = 0, m_y = 0, m_addr = 0, m_dat = 0;
  bit m_err = 0, m_wea = 0, chk_en = 0;

  function automatic int addr_of(int x, int y);
    return MIR ? (y * H + (H - 1 - x)) : (y * H + x);
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_x = 0; m_y = 0; m_err = 0; m_wea = 0; m_addr = 0; m_dat = 0;
      chk_en = 1;
    end else begin
      m_wea = 0;
      case (m_mode)
        0: if (start) begin m_mode = 1; m_err = 0; m_x = 0; m_y = 0; end
        1: if (pix.s_valid && pix.s_sof) begin
             m_wea = 1; m_addr = addr_of(0, 0); m_dat = int'(pix.s_data);
             m_x = 1; m_y = 0; m_mode = 2;
           end
        2: if (pix.s_valid) begin
             m_wea = 1; m_dat = int'(pix.s_data);
             if (pix.s_sof) begin
               m_err = 1; m_addr = addr_of(0, 0); m_x = 1; m_y = 0;
             end else begin
               m_addr = addr_of(m_x, m_y);
               if (pix.s_eol != (m_x == H - 1)) m_err = 1;
               if (m_x == H - 1 && m_y == V - 1) begin
                 m_mode = 3; m_x = 0; m_y = 0;
               end else if (pix.s_eol || m_x == H - 1) begin
                 m_x = 0; m_y++;
               end else begin
                 m_x++;
               end
             end
           end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wea", int'(wea), int'(m_wea));
      check("addra", int'(addra), m_addr);
      check("dina", int'(dina), m_dat);
      check("s_ready", int'(pix.s_ready), int'(m_mode == 1 || m_mode == 2));
      check("busy", int'(busy), int'(m_mode == 1 || m_mode == 2));
      check("done", int'(done), int'(m_mode == 3));
      check("err", int'(err), int'(m_err));
      if (wea) wr_log.push_back(int'(addra));
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(bit sof, bit eol, bit stall);
    while (stall && $urandom_range(1, 0) == 1) begin
      pix.s_valid = 1'b0;
      pix.s_data  = DW'($urandom);
      pix.s_sof   = 1'($urandom);
      pix.s_eol   = 1'($urandom);
      tick();
    end
    pix.s_valid = 1'b1;
    pix.s_data  = DW'($urandom);
    pix.s_sof   = sof;
    pix.s_eol   = eol;
    tick();
    pix.s_valid = 1'b0;
  endtask

  // n well-formed beats starting at raster position (x0, y0)
  task automatic send_run(int x0, int y0, int n, bit stall);
    for (int i = 0; i < n; i++) begin
      int p;
      p = y0 * H + x0 + i;
      send_beat(p == 0, (p % H) == H - 1, stall);
    end
  endtask

  task automatic begin_scenario();
    wr_log.delete();
    done_cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    pix.s_valid = 1'b0; pix.s_data = '0; pix.s_sof = 1'b0; pix.s_eol = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset_addra", int'(addra), 0);
    check("reset_dina", int'(dina), 0);
    check("reset_ready", int'(pix.s_ready), 0);
    check("reset_busy", int'(busy), 0);

    // Full frame, continuous valid
    begin_scenario();
    arm();
    send_run(0, 0, H * V, 1'b0);
    repeat (3) tick();
    check("full_done_cnt", done_cnt, 1);
    check("full_nwrites", wr_log.size(), H * V);
    check("full_first", wr_log[0], MIR ? 19 : 0);
    check("full_second", wr_log[1], MIR ? 18 : 1);
    check("full_third", wr_log[2], MIR ? 17 : 2);
    check("full_line1", wr_log[H], MIR ? 39 : 20);
    check("full_last", wr_log[H * V - 1], MIR ? 100 : 119);
    check("full_err", int'(err), 0);
    check("full_idle", int'(busy), 0);

    // Same frame with random stalls
    begin_scenario();
    arm();
    send_run(0, 0, H * V, 1'b1);
    repeat (3) tick();
    check("stall_done_cnt", done_cnt, 1);
    check("stall_nwrites", wr_log.size(), H * V);
    check("stall_last", wr_log[H * V - 1], MIR ? 100 : 119);

    // Pre-frame garbage, then a short line 0
    begin_scenario();
    arm();
    for (int i = 0; i < 5; i++) send_beat(1'b0, 1'($urandom), 1'b0);
    tick();
    check("garbage_nwrites", wr_log.size(), 0);
    send_run(0, 0, 9, 1'b0);
    send_beat(1'b0, 1'b1, 1'b0);
    send_run(0, 1, H * (V - 1), 1'b0);
    repeat (3) tick();
    check("short_eol_beat", wr_log[9], MIR ? 10 : 9);
    check("short_next_row", wr_log[10], MIR ? 39 : 20);
    check("short_err", int'(err), 1);
    check("short_done_cnt", done_cnt, 1);
    arm();
    check("start_clears_err", int'(err), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Mid-frame sof at y=2, x=5
    begin_scenario();
    arm();
    send_run(0, 0, 2 * H + 5, 1'b0);
    send_beat(1'b1, 1'b0, 1'b0);
    send_run(1, 0, H * V - 1, 1'b0);
    repeat (3) tick();
    check("midsof_addr", wr_log[2 * H + 5], MIR ? 19 : 0);
    check("midsof_next", wr_log[2 * H + 6], MIR ? 18 : 1);
    check("midsof_err", int'(err), 1);
    check("midsof_done_cnt", done_cnt, 1);

    // Reset mid-frame, then a clean frame
    begin_scenario();
    arm();
    send_run(0, 0, 2 * H + 3, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_wea", int'(wea), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ready", int'(pix.s_ready), 0);
    tick();
    begin_scenario();
    arm();
    send_run(0, 0, H * V, 1'b1);
    repeat (3) tick();
    check("post_rst_done_cnt", done_cnt, 1);
    check("post_rst_nwrites", wr_log.size(), H * V);
    check("post_rst_err", int'(err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
